// File: rtl/dbg_chain_master_if.sv
// Command/response bundle between a host bridge (UART or bus) and dbg_chain_master.
// Valid/ready on both directions; the bridge is master, the chain engine is slave.
interface dbg_chain_master_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_step;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_mode, cmd_len, cmd_data, cmd_step, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_len, cmd_data, cmd_step, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/dbg_chain_master.sv
// Drives the sm_top debug shift chain from one command: shift L bits (2*L*CLK_DIV cycles), update, optional CPU step.
// One command in flight; the response is held until rsp_ready and new commands are refused until then.
module dbg_chain_master #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 6,
    parameter int CLK_DIV = 2
) (
    input  logic              clkIn,
    input  logic              rst_n,
    dbg_chain_master_if.slave cmd_if,
    output logic              busy,
    output logic              mode,
    output logic              shift_dr,
    output logic              clk_dr,
    output logic              update_dr,
    output logic              clk_cpu,
    output logic              s_data_in,
    input  logic              s_data_out
);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_UPDATE,
        S_STEP,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  bit_q, bit_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              step_q, step_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic              mode_q, mode_d;
    logic              shift_q, shift_d;
    logic              clk_dr_q, clk_dr_d;
    logic              update_q, update_d;
    logic              clk_cpu_q, clk_cpu_d;
    logic              sdin_q, sdin_d;

    logic              tick;
    logic              accept;
    logic [LEN_W:0]    len_ext;
    logic [IDX_W-1:0]  last_eff;

    assign tick    = (pre_q == PRE_W'(CLK_DIV - 1));
    assign accept  = (state_q == S_IDLE) && cmd_if.cmd_valid && cmd_ready_q;
    assign len_ext = {1'b0, cmd_if.cmd_len};

    // Length is kept as the index of the last bit; 0 or oversize means a full word.
    always_comb begin
        if (len_ext == '0 || len_ext > (LEN_W+1)'(DATA_W)) begin
            last_eff = IDX_W'(DATA_W - 1);
        end else begin
            last_eff = IDX_W'(len_ext - 1'b1);
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_d       = tick ? '0 : pre_q + 1'b1;
        bit_d       = bit_q;
        last_d      = last_q;
        dat_d       = dat_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        step_d      = step_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        clk_dr_d    = clk_dr_q;
        update_d    = update_q;
        clk_cpu_d   = clk_cpu_q;
        sdin_d      = sdin_q;

        case (state_q)
            S_IDLE: begin
                pre_d = '0;
                if (accept) begin
                    state_d     = S_SHIFT;
                    mode_d      = cmd_if.cmd_mode;
                    step_d      = cmd_if.cmd_step;
                    last_d      = last_eff;
                    bit_d       = '0;
                    cap_d       = '0;
                    sdin_d      = cmd_if.cmd_data[0];
                    dat_d       = cmd_if.cmd_data >> 1;
                    shift_d     = 1'b1;
                    clk_dr_d    = 1'b0;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                end
            end

            // clk_dr_q doubles as the half-bit phase: low half ends in a capture, high half in a data advance.
            S_SHIFT: begin
                if (tick) begin
                    if (!clk_dr_q) begin
                        clk_dr_d     = 1'b1;
                        cap_d[bit_q] = s_data_out;
                    end else begin
                        clk_dr_d = 1'b0;
                        if (bit_q == last_q) begin
                            state_d  = S_UPDATE;
                            pre_d    = '0;
                            shift_d  = 1'b0;
                            sdin_d   = 1'b0;
                            update_d = 1'b1;
                        end else begin
                            sdin_d = dat_q[0];
                            dat_d  = dat_q >> 1;
                            bit_d  = bit_q + 1'b1;
                        end
                    end
                end
            end

            S_UPDATE: begin
                if (tick) begin
                    update_d = 1'b0;
                    pre_d    = '0;
                    if (step_q) begin
                        state_d   = S_STEP;
                        clk_cpu_d = 1'b1;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cap_q;
                    end
                end
            end

            // High phase then an equal low phase before the response, so the CPU clock is a full period.
            S_STEP: begin
                if (tick) begin
                    if (clk_cpu_q) begin
                        clk_cpu_d = 1'b0;
                    end else begin
                        state_d     = S_RESP;
                        pre_d       = '0;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cap_q;
                    end
                end
            end

            S_RESP: begin
                pre_d = '0;
                if (cmd_if.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    mode_d      = 1'b0;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                pre_d       = '0;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                mode_d      = 1'b0;
                shift_d     = 1'b0;
                clk_dr_d    = 1'b0;
                update_d    = 1'b0;
                clk_cpu_d   = 1'b0;
                sdin_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            bit_q       <= '0;
            last_q      <= '0;
            dat_q       <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            step_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mode_q      <= 1'b0;
            shift_q     <= 1'b0;
            clk_dr_q    <= 1'b0;
            update_q    <= 1'b0;
            clk_cpu_q   <= 1'b0;
            sdin_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            bit_q       <= bit_d;
            last_q      <= last_d;
            dat_q       <= dat_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            step_q      <= step_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            clk_dr_q    <= clk_dr_d;
            update_q    <= update_d;
            clk_cpu_q   <= clk_cpu_d;
            sdin_q      <= sdin_d;
        end
    end

    assign cmd_if.cmd_ready = cmd_ready_q;
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_data  = rsp_data_q;
    assign busy             = busy_q;
    assign mode             = mode_q;
    assign shift_dr         = shift_q;
    assign clk_dr           = clk_dr_q;
    assign update_dr        = update_q;
    assign clk_cpu          = clk_cpu_q;
    assign s_data_in        = sdin_q;
endmodule

// File: tb/tb_dbg_chain_master.sv
// Directed bench for dbg_chain_master: reset, shift/capture, full-word, step pulse, backpressure, mid-shift reset.
`timescale 1ns/1ps
module tb_dbg_chain_master;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 6;
    localparam int CLK_DIV = 2;

    logic clkIn = 1'b0;
    logic rst_n = 1'b0;
    logic busy, mode, shift_dr, clk_dr, update_dr, clk_cpu, s_data_in, s_data_out;

    dbg_chain_master_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) cif ();

    dbg_chain_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
        .clkIn      (clkIn),
        .rst_n      (rst_n),
        .cmd_if     (cif),
        .busy       (busy),
        .mode       (mode),
        .shift_dr   (shift_dr),
        .clk_dr     (clk_dr),
        .update_dr  (update_dr),
        .clk_cpu    (clk_cpu),
        .s_data_in  (s_data_in),
        .s_data_out (s_data_out)
    );

    always #5 clkIn = ~clkIn;

    // Chain model: either loopback or a fixed pattern presented LSB first, advancing on each clk_dr fall.
    logic        loopback  = 1'b1;
    logic [31:0] chain_pat = 32'h0;
    int          fall_cnt  = 0;
    int          fall_base = 0;
    always @(negedge clk_dr) fall_cnt <= fall_cnt + 1;
    assign s_data_out = loopback ? s_data_in : chain_pat[5'(fall_cnt - fall_base)];

    int n_assert = 0;
    int n_fail   = 0;

    int          n_shift, n_rise, n_upd, n_cpu, n_cpu_rise, gap_bad, overlap, cpu_start_bad;
    logic [31:0] din_word;
    logic [7:0]  first_vec;
    logic        timeout;

    localparam logic [9:0] RST_VEC = 10'b10_0000_0000;

    function automatic logic [9:0] outs();
        return {cif.cmd_ready, cif.rsp_valid, busy, mode, shift_dr, clk_dr,
                update_dr, clk_cpu, s_data_in, |cif.rsp_data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and watch the chain pins until rsp_valid (or the given clk_dr rise count).
    task automatic run_cmd(input logic m, input logic [5:0] len, input logic [31:0] d,
                           input logic st, input int abort_rise);
        int   last_rise;
        logic p_clk, p_upd, p_cpu;
        n_shift = 0; n_rise = 0; n_upd = 0; n_cpu = 0; n_cpu_rise = 0;
        gap_bad = 0; overlap = 0; cpu_start_bad = 0; din_word = '0;
        timeout = 1'b0; first_vec = '0;
        fall_base = fall_cnt;
        @(negedge clkIn);
        cif.cmd_valid = 1'b1; cif.cmd_mode = m; cif.cmd_len = len;
        cif.cmd_data  = d;    cif.cmd_step = st;
        for (int c = 0; c < 20; c++) begin
            @(posedge clkIn); #1;
            if (busy) break;
        end
        if (!busy) begin
            timeout = 1'b1;
            cif.cmd_valid = 1'b0;
        end else begin
            first_vec = {busy, cif.cmd_ready, mode, shift_dr, clk_dr, s_data_in, update_dr, clk_cpu};
            // Later changes to the command inputs must not matter.
            cif.cmd_valid = 1'b0; cif.cmd_data = ~d; cif.cmd_mode = ~m;
            cif.cmd_len = 6'd3; cif.cmd_step = ~st;
            p_clk = 1'b0; p_upd = 1'b0; p_cpu = 1'b0; last_rise = -100;
            for (int c = 0; c < 3000; c++) begin
                if (cif.rsp_valid) break;
                if (shift_dr)  n_shift++;
                if (update_dr) n_upd++;
                if (clk_cpu)   n_cpu++;
                if (clk_dr && !p_clk) begin
                    if (n_rise < 32) din_word[n_rise[4:0]] = s_data_in;
                    if (n_rise > 0 && (c - last_rise) != 4) gap_bad++;
                    last_rise = c;
                    n_rise++;
                end
                if (clk_cpu && !p_cpu) begin
                    n_cpu_rise++;
                    if (!(p_upd && !update_dr)) cpu_start_bad++;
                end
                if ((int'(clk_dr) + int'(update_dr) + int'(clk_cpu)) > 1 || (shift_dr && update_dr))
                    overlap++;
                if (abort_rise > 0 && n_rise == abort_rise) break;
                p_clk = clk_dr; p_upd = update_dr; p_cpu = clk_cpu;
                @(posedge clkIn); #1;
            end
            if (abort_rise == 0) timeout = !cif.rsp_valid;
        end
    endtask

    task automatic ack(output logic [9:0] after);
        @(negedge clkIn); cif.rsp_ready = 1'b1;
        @(posedge clkIn); #1;
        after = outs();
        @(negedge clkIn); cif.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] v;
        int         bad;
        cif.cmd_valid = 1'b0; cif.cmd_mode = 1'b0; cif.cmd_len = '0;
        cif.cmd_data  = '0;   cif.cmd_step = 1'b0; cif.rsp_ready = 1'b0;

        // Reset with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clkIn);
            cif.cmd_valid = 1'($urandom); cif.cmd_mode = 1'($urandom);
            cif.cmd_len   = 6'($urandom); cif.cmd_data = $urandom;
            cif.cmd_step  = 1'($urandom); cif.rsp_ready = 1'($urandom);
            loopback      = 1'($urandom);
            #2;
            chk("reset_outputs", 32'(outs()), 32'(RST_VEC));
            chk("reset_rsp_data", cif.rsp_data, 32'h0);
        end
        @(negedge clkIn);
        cif.cmd_valid = 1'b0; cif.rsp_ready = 1'b0; loopback = 1'b1;
        #2 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clkIn); #1;
            if (outs() !== RST_VEC) bad++;
        end
        chk("idle_quiet_after_reset", 32'(bad), 32'h0);

        // 8-bit shift of 0xA5 against a chain returning 0x3C, mode=1
        loopback = 1'b0; chain_pat = 32'h0000_003C;
        run_cmd(1'b1, 6'd8, 32'h0000_00A5, 1'b0, 0);
        chk("t1_timeout", 32'(timeout), 32'h0);
        chk("t1_first_cycle", 32'(first_vec), 32'h0000_00B4);
        chk("t1_rises", n_rise, 8);
        chk("t1_din_at_rises", din_word, 32'h0000_00A5);
        chk("t1_rise_spacing", gap_bad, 0);
        chk("t1_shift_cycles", n_shift, 32);
        chk("t1_update_cycles", n_upd, 2);
        chk("t1_no_cpu_clk", n_cpu, 0);
        chk("t1_overlap", overlap, 0);
        chk("t1_rsp_data", cif.rsp_data, 32'h0000_003C);
        chk("t1_mode_in_resp", 32'(mode), 32'h1);

        // Backpressure: response stalls 10 cycles with a competing command pending
        @(negedge clkIn);
        cif.cmd_valid = 1'b1; cif.cmd_data = 32'h1234_5678; cif.cmd_len = 6'd4;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clkIn); #1;
            if (cif.rsp_valid !== 1'b1 || cif.rsp_data !== 32'h3C || cif.cmd_ready !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        chk("bp_stable", bad, 0);
        @(negedge clkIn); cif.rsp_ready = 1'b1; cif.cmd_valid = 1'b0;
        @(posedge clkIn); #1;
        chk("bp_after_ack", 32'(outs()), 32'h0000_0201);
        chk("bp_rsp_data_held", cif.rsp_data, 32'h0000_003C);
        @(negedge clkIn); cif.rsp_ready = 1'b0;
        repeat (3) @(posedge clkIn);
        #1 chk("bp_second_cmd_dropped", 32'(busy), 32'h0);

        // Full-word shift via cmd_len=0, loopback
        loopback = 1'b1;
        run_cmd(1'b0, 6'd0, 32'hDEAD_BEEF, 1'b0, 0);
        chk("t2_timeout", 32'(timeout), 32'h0);
        chk("t2_rises", n_rise, 32);
        chk("t2_din_at_rises", din_word, 32'hDEAD_BEEF);
        chk("t2_shift_cycles", n_shift, 128);
        chk("t2_rise_spacing", gap_bad, 0);
        chk("t2_rsp_data", cif.rsp_data, 32'hDEAD_BEEF);
        ack(v);
        chk("t2_ack_ready", 32'(v[9]), 32'h1);

        // Single bit with CPU step; upper response bits must be zero
        run_cmd(1'b0, 6'd1, 32'hFFFF_FFFF, 1'b1, 0);
        chk("t3_timeout", 32'(timeout), 32'h0);
        chk("t3_rises", n_rise, 1);
        chk("t3_shift_cycles", n_shift, 4);
        chk("t3_update_cycles", n_upd, 2);
        chk("t3_cpu_cycles", n_cpu, 2);
        chk("t3_cpu_pulses", n_cpu_rise, 1);
        chk("t3_cpu_after_update", cpu_start_bad, 0);
        chk("t3_overlap", overlap, 0);
        chk("t3_rsp_data", cif.rsp_data, 32'h0000_0001);
        ack(v);

        // Oversize length clamps to a full word
        run_cmd(1'b0, 6'd40, 32'h0F0F_1234, 1'b0, 0);
        chk("t4_rises", n_rise, 32);
        chk("t4_rsp_data", cif.rsp_data, 32'h0F0F_1234);
        ack(v);

        // Reset after the 5th clk_dr rise
        run_cmd(1'b1, 6'd8, 32'h0000_005A, 1'b0, 5);
        chk("t5_rises_before_reset", n_rise, 5);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_reset_outputs", 32'(outs()), 32'(RST_VEC));
        @(negedge clkIn); #2 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clkIn); #1;
            if (cif.rsp_valid !== 1'b0 || busy !== 1'b0 || cif.cmd_ready !== 1'b1) bad++;
        end
        chk("t5_no_response_after_reset", bad, 0);
        run_cmd(1'b0, 6'd16, 32'h0000_C3A5, 1'b0, 0);
        chk("t5_next_timeout", 32'(timeout), 32'h0);
        chk("t5_next_rises", n_rise, 16);
        chk("t5_next_rsp_data", cif.rsp_data, 32'h0000_C3A5);
        ack(v);
        chk("t5_next_ack", 32'(v), 32'h0000_0201);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dbg_chain_master.md
Name: dbg_chain_master

Overview:
- Fabric-side initiator for the sm_top debug shift chain. It generates mode, shift_dr, clk_dr, update_dr, clk_cpu and s_data_in, and captures s_data_out.
- Replaces the processor-subsystem SPI and GPIO bit-banging with one command/response engine.
- The command side connects to a UART or bus bridge. The chain side connects directly to the sm_top debug pins.

Parameters:
- DATA_W, 32, width of the command data and the captured response data.
- LEN_W, 6, width of cmd_len.
- CLK_DIV, 2, clkIn cycles per clk_dr half-period (one "tick"); minimum 1.

Ports:
- clkIn  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  engine idle and able to accept a command
- cmd_mode  input  1  value driven on mode for the whole transaction
- cmd_len  input  LEN_W  number of bits to shift; 0 or >DATA_W means DATA_W
- cmd_data  input  DATA_W  shift-out data, LSB first
- cmd_step  input  1  issue one clk_cpu pulse after update
- rsp_valid  output  1  captured data available
- rsp_ready  input  1  response accepted
- rsp_data  output  DATA_W  captured chain data, right-aligned
- busy  output  1  transaction in progress (any state other than IDLE)
- mode  output  1  chain mode select
- shift_dr  output  1  chain shift enable
- clk_dr  output  1  chain shift clock
- update_dr  output  1  chain update strobe
- clk_cpu  output  1  single-step CPU clock
- s_data_in  output  1  serial data to chain
- s_data_out  input  1  serial data from chain

Behaviour:
- Reset (async, rst_n=0): every output is 0 except cmd_ready=1. That is: rsp_valid, rsp_data, busy, mode, shift_dr, clk_dr, update_dr, clk_cpu, s_data_in all 0; FSM in IDLE; prescaler, bit counter and capture register cleared.
- Prescaler: counts 0..CLK_DIV-1 and emits a tick on wrap. It is cleared on command accept and on every state entry.
- FSM: IDLE -> SHIFT -> UPDATE -> (STEP if cmd_step) -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - Accept when cmd_valid & cmd_ready at a clkIn edge; latch mode, effective length L, data and step.
  - On the next cycle: mode=cmd_mode, shift_dr=1, s_data_in=cmd_data[0], clk_dr=0, busy=1, cmd_ready=0.
- SHIFT:
  - Each bit takes 2 ticks: clk_dr low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the clkIn edge that raises clk_dr, s_data_out is sampled as capture bit i (i = 0..L-1).
  - On the edge that lowers clk_dr, s_data_in advances to data[i+1].
  - After the L-th falling edge: shift_dr=0, s_data_in=0, go to UPDATE.
  - SHIFT duration is exactly 2*L*CLK_DIV cycles.
- UPDATE: update_dr=1 for CLK_DIV cycles, then 0.
- STEP: clk_cpu=1 for CLK_DIV cycles, then 0 for CLK_DIV cycles.
- RESP:
  - rsp_valid=1; rsp_data[L-1:0]=captured bits (bit i = i-th sample); rsp_data[DATA_W-1:L]=0.
  - rsp_data is held stable until rsp_valid & rsp_ready.
  - Then: rsp_valid=0, mode=0, busy=0, cmd_ready=1 on the next cycle.
- cmd_ready is 0 while rsp_valid=1. cmd_valid outside IDLE is ignored, not queued.
- Command inputs are sampled only at accept; later changes have no effect.
- rsp_data holds its last value after handshake until the next RESP.
- clk_dr, update_dr and clk_cpu never overlap; shift_dr and update_dr are never both 1.
- Reset asserted mid-transaction: outputs return to reset values immediately. The transaction is discarded and no response is produced.
- All outputs are registered (no combinational path from input to output).

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> cmd_ready=1, all other outputs 0. Release rst_n -> nothing toggles until cmd_valid.
- CLK_DIV=2, cmd_len=8, cmd_data=0xA5, chain model returns 0x3C LSB-first:
  - s_data_in at the 8 clk_dr rises reads 1,0,1,0,0,1,0,1.
  - Rises are 4 clkIn cycles apart; shift_dr is high for 32 cycles.
  - update_dr is high for 2 cycles.
  - rsp_data=0x0000003C.
- cmd_len=0 with loopback (s_data_out=s_data_in), cmd_data=0xDEADBEEF -> 32 clk_dr pulses, rsp_data=0xDEADBEEF.
- cmd_step=1, cmd_len=1 -> exactly one clk_cpu pulse, 2 cycles wide, starting when update_dr falls. cmd_step=0 -> no clk_cpu activity.
- Response backpressure: rsp_ready=0 for 10 cycles while cmd_valid=1 with new data:
  - rsp_valid and rsp_data stay stable; cmd_ready=0; the second command is not accepted.
  - After rsp_ready=1, cmd_ready=1 on the next cycle.
- Drop rst_n after the 5th clk_dr rise -> all chain outputs 0 asynchronously. After release: cmd_ready=1, rsp_valid never asserts, and the next command completes normally.
